// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the parametrised UART receiver and transmitter.
// Holds the FSM state encoding, parity-mode constants and parameter range helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  function automatic bit stop_bits_ok(input int n);
    return (n == 1) || (n == 2);
  endfunction

endpackage

// File: rtl/uart_in_sync.sv
// uart_in_sync: 2-flop synchroniser for the asynchronous serial line, resets to idle (1).
// Latency: 2 clk cycles.
// Backpressure: none; free-running every cycle.
module uart_in_sync (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic line_s
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b1;
      line_s <= 1'b1;
    end else begin
      meta   <= line;
      line_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver; parity bit/check compiled in by UART_RX_PARITY_EN.
// Latency: out_valid/error one cycle after the final stop sample (t0+77 for 8N1 at x8).
// Backpressure: none; the consumer must capture out_reg on the out_valid strobe.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_bit,
  output logic [DATA_W-1:0] out_reg,
  output logic              out_valid,
  output logic              busy,
  output logic              error,
  output logic              parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] OS_M1   = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_M1 = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_M1 = BW'(STOP_BITS - 1);

  if (!stop_bits_ok(STOP_BITS) || DATA_W < 5 || DATA_W > 9 || OVERSAMPLE < 4 ||
      (OVERSAMPLE % 2) != 0 || (PARITY_ODD != PAR_EVEN && PARITY_ODD != PAR_ODD)) begin : g_bad_param
    $error("uart_rx_cfg: parameter out of range");
  end

  logic              rx_s;
  rx_state_t         state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [BW-1:0]     bcnt, bcnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              stop_bad, stop_bad_nxt;
  logic              par_ok;
  logic              frame_done, frame_good;

  uart_in_sync u_in_sync (
    .clk    (clk),
    .reset  (reset),
    .line   (in_bit),
    .line_s (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = logic'(PARITY_ODD == PAR_ODD);
  logic par_bad, par_bad_nxt;
  assign par_ok = !par_bad;
`else
  assign par_ok = 1'b1;
`endif

  assign busy = enable && (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bcnt_nxt     = bcnt;
    shreg_nxt    = shreg;
    stop_bad_nxt = stop_bad;
    frame_done   = 1'b0;
    frame_good   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt  = par_bad;
`endif
    if (!enable) begin
      // Abort: the ARM high-count restarts from zero once re-enabled.
      state_nxt = ST_ARM;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_ARM: begin
          if (!rx_s) begin
            cnt_nxt = '0;
          end else if (cnt == OS_M1) begin
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_IDLE: begin
          if (!rx_s) begin
            state_nxt = ST_START;
            cnt_nxt   = '0;
          end
        end
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt_nxt      = '0;
            bcnt_nxt     = '0;
            stop_bad_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_nxt  = 1'b0;
`endif
            // A high line at mid-start is a glitch, not a frame.
            state_nxt = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == OS_M1) begin
            cnt_nxt   = '0;
            shreg_nxt = {rx_s, shreg[DATA_W-1:1]};
            if (bcnt == DATA_M1) begin
              bcnt_nxt  = '0;
`ifdef UART_RX_PARITY_EN
              state_nxt = ST_PARITY;
`else
              state_nxt = ST_STOP;
`endif
            end else begin
              bcnt_nxt = bcnt + BW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == OS_M1) begin
            cnt_nxt     = '0;
            par_bad_nxt = rx_s != ((^shreg) ^ ODD);
            state_nxt   = ST_STOP;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt == OS_M1) begin
            cnt_nxt = '0;
            if (bcnt == STOP_M1) begin
              // Straight back to IDLE so a back-to-back start edge is caught.
              frame_done = 1'b1;
              frame_good = !stop_bad && rx_s && par_ok;
              bcnt_nxt   = '0;
              state_nxt  = ST_IDLE;
            end else begin
              stop_bad_nxt = stop_bad || !rx_s;
              bcnt_nxt     = bcnt + BW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = ST_ARM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ARM;
      cnt       <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      stop_bad  <= 1'b0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bcnt      <= bcnt_nxt;
      shreg     <= shreg_nxt;
      stop_bad  <= stop_bad_nxt;
      out_valid <= frame_done && frame_good;
      error     <= frame_done && !frame_good;
      if (frame_done && frame_good) begin
        out_reg <= shreg;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_nxt;
      parity_err <= frame_done && par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed plus randomized frames against a frame-level outcome model.
module tb_uart_rx_cfg;

`ifdef UART_RX_PARITY_EN
  localparam int TDW   = 7;
  localparam int TSTOP = 2;
  localparam int TPB   = 1;
`else
  localparam int TDW   = 8;
  localparam int TSTOP = 1;
  localparam int TPB   = 0;
`endif
  localparam int OS  = 8;
  // Drive cycle of the start edge to the frame-end pulse: 2 sync + mid-bit + bits + 1.
  localparam int LAT = 2 + OS / 2 + (TDW + TPB + TSTOP) * OS + 1;

  logic           clk = 1'b0;
  logic           reset, enable, in_bit;
  logic [TDW-1:0] out_reg;
  logic           out_valid, busy, error, parity_err;

  uart_rx_cfg #(
    .DATA_W     (TDW),
    .OVERSAMPLE (OS),
    .STOP_BITS  (TSTOP),
    .PARITY_ODD (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .in_bit     (in_bit),
    .out_reg    (out_reg),
    .out_valid  (out_valid),
    .busy       (busy),
    .error      (error),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed activity, sampled 1 ns after each rising edge.
  int             cyc = 0;
  int             n_valid = 0, n_err = 0, n_perr = 0, n_overlap = 0;
  int             last_pulse_cyc = 0;
  logic           busy_at_pulse = 1'b1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (out_valid) n_valid++;
    if (error) n_err++;
    if (parity_err) n_perr++;
    if (out_valid && error) n_overlap++;
    if (parity_err && !error) n_overlap++;
    if (out_valid || error) begin
      last_pulse_cyc = cyc;
      busy_at_pulse  = busy;
    end
  end

  // Reference model: expected outcome counts and last good word.
  int             exp_valid = 0, exp_err = 0, exp_perr = 0;
  logic [TDW-1:0] exp_word = '0;
  int             start_cyc = 0;
  logic           busy_mid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    in_bit = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [TDW-1:0] d, input logic stop_v, input logic flip);
    logic good;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < TDW; i++) begin
      drive_bit(d[i]);
      if (i == 1) busy_mid = busy;
    end
    if (TPB != 0) drive_bit((^d) ^ flip);
    for (int s = 0; s < TSTOP; s++) drive_bit(stop_v);
    good = stop_v && !((TPB != 0) && flip);
    if (good) begin
      exp_valid++;
      exp_word = d;
    end else begin
      exp_err++;
    end
    if ((TPB != 0) && flip) exp_perr++;
  endtask

  task automatic check_frame(input string tag);
    check({tag, " valid_count"}, 32'(n_valid), 32'(exp_valid));
    check({tag, " error_count"}, 32'(n_err), 32'(exp_err));
    check({tag, " parity_count"}, 32'(n_perr), 32'(exp_perr));
    check({tag, " out_reg"}, 32'(out_reg), 32'(exp_word));
    check({tag, " busy_mid"}, 32'(busy_mid), 32'd1);
  endtask

  logic [TDW-1:0] rd;
  logic           sv, fl;
  int             gap;

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    in_bit = 1'b1;
    repeat (3) @(negedge clk);
    check("reset out_reg", 32'(out_reg), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset error", 32'(error), 32'd0);
    check("reset parity_err", 32'(parity_err), 32'd0);
    reset = 1'b0;
    repeat (2 * OS) @(negedge clk);

    // Two back-to-back frames, no idle between them.
    send_frame(TDW'(8'h55), 1'b1, 1'b0);
    check("f55 latency", 32'(last_pulse_cyc - start_cyc), 32'(LAT));
    check("f55 busy_at_pulse", 32'(busy_at_pulse), 32'd0);
    check_frame("f55");
    send_frame(TDW'(8'h5C), 1'b1, 1'b0);
    check("f5c latency", 32'(last_pulse_cyc - start_cyc), 32'(LAT));
    check_frame("f5c");

    // Framing error: stop bit low.
    send_frame(TDW'(8'hD4), 1'b0, 1'b0);
    check("fd4 err latency", 32'(last_pulse_cyc - start_cyc), 32'(LAT));
    check("fd4 busy_at_pulse", 32'(busy_at_pulse), 32'd0);
    check_frame("fd4");
    in_bit = 1'b1;
    repeat (2 * OS) @(negedge clk);
    check("fd4 recovered busy", 32'(busy), 32'd0);

    // Start-bit glitch: two low clocks.
    in_bit = 1'b0;
    repeat (2) @(negedge clk);
    in_bit = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch busy rise", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
    check("glitch busy fall", 32'(busy), 32'd0);
    check_frame("glitch");

    // Abort during data bit 3, then re-arm and receive 0xA5.
    rd = TDW'(8'h3C);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(rd[i]);
    in_bit = rd[3];
    repeat (OS / 2) @(negedge clk);
    check("pre-abort busy", 32'(busy), 32'd1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    in_bit = 1'b1;
    repeat (OS) @(negedge clk);
    enable = 1'b1;
    repeat (2 * OS) @(negedge clk);
    send_frame(TDW'(8'hA5), 1'b1, 1'b0);
    check_frame("abort_a5");

`ifdef UART_RX_PARITY_EN
    send_frame(TDW'(8'h41), 1'b1, 1'b0);
    check_frame("par_good");
    send_frame(TDW'(8'h41), 1'b1, 1'b1);
    check("par_bad latency", 32'(last_pulse_cyc - start_cyc), 32'(LAT));
    check_frame("par_bad");
`endif

    // Randomized frames with random gaps, framing and parity faults.
    for (int f = 0; f < 24; f++) begin
      rd = TDW'($urandom);
      sv = ($urandom_range(0, 4) != 0);
      fl = (TPB != 0) && ($urandom_range(0, 3) == 0);
      send_frame(rd, sv, fl);
      check_frame("rand");
      in_bit = 1'b1;
      gap = sv ? $urandom_range(0, 3) : 2 * OS;
      repeat (gap) @(negedge clk);
    end

    // Reset in the middle of a frame.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst out_reg", 32'(out_reg), 32'd0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    exp_word = '0;
    in_bit = 1'b1;
    repeat (2 * OS) @(negedge clk);
    rd = TDW'($urandom);
    send_frame(rd, 1'b1, 1'b0);
    check_frame("post_rst");

    check("valid/error overlap", 32'(n_overlap), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised, oversampling UART receiver. It is the next generation of the fixed 8N1 `Rx`, with configurable data width, oversample ratio and stop-bit count, and an optional parity check. It adds a one-cycle `out_valid` strobe, glitch rejection on the start bit, and safe re-arming after an abort. It sits between the serial pin and the byte-level consumer, in the same clock domain as the transmitter's bit-rate generator.

## Interface
- `DATA_W`, 8: data bits per frame, 5..9.
- `OVERSAMPLE`, 8: clocks per bit; must be even and ≥4.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only when `UART_RX_PARITY_EN` is defined.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: receiver enable. Low aborts any frame in progress.
- `in_bit` in 1: asynchronous serial line. Idle level is 1.
- `out_reg` out DATA_W: last good received word, LSB received first. Holds its value until the next good frame.
- `out_valid` out 1: one-cycle pulse when `out_reg` is updated.
- `busy` out 1: high from start detect until the frame ends or is aborted.
- `error` out 1: one-cycle pulse at frame end for a framing or parity error.
- `parity_err` out 1: one-cycle pulse, coincident with `error`, when the parity check fails.

## Operation
- `in_bit` passes through a 2-flop synchroniser; the result is `rx_s`. All decisions use `rx_s`.
- State machine states: ARM, IDLE, START, DATA, PARITY, STOP.
- ARM: count consecutive high `rx_s` samples. After `OVERSAMPLE` of them, go to IDLE. Any low sample restarts the count.
- IDLE: `rx_s`=0 → START; oversample counter cleared; `busy`=1.
- START: at counter = `OVERSAMPLE/2-1` (mid-bit), sample `rx_s`.
  - `rx_s`=1 → glitch. Return to IDLE, `busy`=0, no `error` pulse.
  - `rx_s`=0 → DATA; counter restarts.
- DATA: sample every `OVERSAMPLE` clocks. Each sample shifts into the shift register from the MSB end, so the first data bit lands in bit 0 once `DATA_W` bits are in. After `DATA_W` samples go to PARITY if parity is compiled in, otherwise to STOP.
- PARITY: one sample, compared against the XOR of the data bits, inverted when `PARITY_ODD`=1.
- STOP: `STOP_BITS` samples, all of which must be 1.
- After the last stop sample:
  - Good frame: `out_reg` ← shift register, `out_valid`=1.
  - Otherwise: `error`=1, plus `parity_err` if parity failed. `out_reg` is unchanged.
  - In both cases go directly to IDLE, not ARM, so back-to-back frames are accepted.
- `enable`=0 in any state: go to ARM next cycle, `busy`=0, no pulses. The ARM high-count is held at 0 while `enable`=0.
- Oversample counter width is `$clog2(OVERSAMPLE)`. Bit counter width is `$clog2(DATA_W+1)`. Both wrap only under FSM control.

## Timing
- Reset values: `out_reg`=0, `out_valid`=0, `busy`=0, `error`=0, `parity_err`=0. State = ARM. Synchroniser flops = 1.
- Reset mid-frame behaves exactly like reset from idle.
- Let t0 be the cycle IDLE sees `rx_s`=0 (`in_bit` falling edge + 2 cycles).
- Bit k of the frame, with start = 0, is sampled at t0 + `OVERSAMPLE/2` + k·`OVERSAMPLE`.
- `out_valid`/`error` assert one cycle after the final stop sample. For 8N1 with `OVERSAMPLE`=8 that is t0+77.
- `busy` rises at t0+1 and falls in the same cycle that `out_valid`/`error` assert.
- `out_valid` and `error` are never high together.
- A start edge arriving in the cycle the frame-end pulses assert is taken: IDLE is entered in that cycle.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: one parity bit follows the data; the PARITY state exists; `parity_err` is live.
  - Undefined: no parity bit; PARITY state and parity logic are absent; `parity_err` is tied 0; `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`: FSM state enum, parity-mode constants `PAR_EVEN`/`PAR_ODD`, and a `STOP_BITS` range check. The package is shared with the future parametrised transmitter.
- One sub-module, `uart_in_sync`: 2-flop synchroniser with reset value 1. Everything else stays in `uart_rx_cfg`.

## Test plan
- Defaults (8N1, ×8), bit period 80 ns. Drive bits 1,0,1,0,1,0,1,0 → `out_reg`=0x55, one `out_valid` pulse, `error`=0.
- The next frame starts immediately after the stop bit, bits 0,0,1,1,1,0,1,0 → `out_reg`=0x5C with no lost frame.
- Frame 0xD4 sent with stop bit = 0 → `error` pulse, `out_valid`=0, `out_reg` stays 0x5C.
- `in_bit` low for 2 clocks, then high → no `out_valid`, no `error`, `busy` returns to 0 within `OVERSAMPLE/2`+1 cycles.
- `enable` dropped during data bit 3, raised with the line high for ≥8 clocks, then frame 0xA5 sent → aborted frame yields nothing; 0xA5 is received.
- With `UART_RX_PARITY_EN`, `PARITY_ODD`=0, `DATA_W`=7, `STOP_BITS`=2: 0x41 with parity bit 0 → valid; same data with parity bit 1 → `error` and `parity_err` pulse.
